// File: rtl/data_memory_be_if.sv
// rtl/data_memory_be_if.sv - data bus bundle between the load/store unit and data_memory_be
interface data_memory_be_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  Req_i;
  logic                  Write_Enable_i;
  logic [1:0]            Size_i;
  logic                  Unsigned_i;
  logic [ADDR_WIDTH-1:0] Address_i;
  logic [DATA_WIDTH-1:0] Write_Data_i;
  logic [DATA_WIDTH-1:0] Read_Data_o;
  logic                  Read_Valid_o;
  logic                  Error_o;

  modport master (
    output Req_i, Write_Enable_i, Size_i, Unsigned_i, Address_i, Write_Data_i,
    input  Read_Data_o, Read_Valid_o, Error_o
  );

  modport slave (
    input  Req_i, Write_Enable_i, Size_i, Unsigned_i, Address_i, Write_Data_i,
    output Read_Data_o, Read_Valid_o, Error_o
  );
endinterface

// File: rtl/data_memory_be.sv
// rtl/data_memory_be.sv - byte-addressed data memory with lane strobes and extended registered loads
module data_memory_be #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 64,
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h10010000
) (
  input logic              clk,
  input logic              reset,
  data_memory_be_if.slave  bus
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int IDX_W  = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(MEMORY_DEPTH * BYTES);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

  logic [ADDR_WIDTH-1:0] offset;
  logic [IDX_W-1:0]      widx;
  logic [LANE_W-1:0]     lane;
  logic                  range_err;
  logic                  align_err;
  logic                  acc_err;
  logic                  do_store;
  logic                  do_load;
  logic [BYTES-1:0]      be;
  logic [DATA_WIDTH-1:0] wlane;
  logic [DATA_WIDTH-1:0] rd_shift;
  logic [DATA_WIDTH-1:0] ext;
  logic                  sign_bit;

  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rvalid_q;
  logic                  err_q;

  // Decode the byte address into word index, lane and the reject conditions.
  always_comb begin
    offset    = bus.Address_i - BASE_ADDR;
    widx      = IDX_W'(offset / ADDR_WIDTH'(BYTES));
    lane      = LANE_W'(offset % ADDR_WIDTH'(BYTES));
    range_err = (bus.Address_i < BASE_ADDR) || (offset >= SPAN);
    case (bus.Size_i)
      SZ_BYTE: align_err = 1'b0;
      SZ_HALF: align_err = lane[0];
      SZ_WORD: align_err = (lane != '0);
      default: align_err = 1'b1;
    endcase
    acc_err  = range_err || align_err;
    do_store = bus.Req_i && bus.Write_Enable_i && !acc_err;
    do_load  = bus.Req_i && !bus.Write_Enable_i && !acc_err;
  end

  // Build the lane strobes and place the right-justified store data onto its lanes.
  always_comb begin
    be    = '0;
    wlane = '0;
    for (int l = 0; l < BYTES; l++) begin
      case (bus.Size_i)
        SZ_BYTE: begin
          be[l]           = (LANE_W'(l) == lane);
          wlane[8*l +: 8] = bus.Write_Data_i[7:0];
        end
        SZ_HALF: begin
          be[l]           = (LANE_W'(l) == lane) || (LANE_W'(l) == lane + LANE_W'(1));
          wlane[8*l +: 8] = (l % 2 == 0) ? bus.Write_Data_i[7:0] : bus.Write_Data_i[15:8];
        end
        default: begin
          be[l]           = 1'b1;
          wlane[8*l +: 8] = bus.Write_Data_i[8*l +: 8];
        end
      endcase
    end
  end

  // Select the addressed byte/half from the stored word and extend it.
  always_comb begin
    rd_shift = mem[widx] >> {lane, 3'b000};
    ext      = rd_shift;
    sign_bit = 1'b0;
    case (bus.Size_i)
      SZ_BYTE: begin
        sign_bit  = !bus.Unsigned_i && rd_shift[7];
        ext       = {DATA_WIDTH{sign_bit}};
        ext[7:0]  = rd_shift[7:0];
      end
      SZ_HALF: begin
        sign_bit  = !bus.Unsigned_i && rd_shift[15];
        ext       = {DATA_WIDTH{sign_bit}};
        ext[15:0] = rd_shift[15:0];
      end
      default: ext = rd_shift;
    endcase
  end

  // Commit stores lane by lane; the array is never cleared and reset blocks new writes.
  always_ff @(posedge clk) begin
    if (reset && do_store) begin
      for (int l = 0; l < BYTES; l++) begin
        if (be[l]) begin
          mem[widx][8*l +: 8] <= wlane[8*l +: 8];
        end
      end
    end
  end

  // Register load results and the one-cycle valid/error pulses; read data holds otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= do_load;
      err_q    <= bus.Req_i && acc_err;
      if (do_load) begin
        rdata_q <= ext;
      end
    end
  end

  assign bus.Read_Data_o  = rdata_q;
  assign bus.Read_Valid_o = rvalid_q;
  assign bus.Error_o      = err_q;

endmodule

// File: tb/tb_data_memory_be.sv
// tb/tb_data_memory_be.sv - directed self-checking bench for data_memory_be
module tb_data_memory_be;

  localparam logic [31:0] B = 32'h10010000;
  localparam logic [1:0]  SZB = 2'b00;
  localparam logic [1:0]  SZH = 2'b01;
  localparam logic [1:0]  SZW = 2'b10;
  localparam logic [1:0]  SZX = 2'b11;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_mis;

  data_memory_be_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  data_memory_be #(
    .DATA_WIDTH(32), .MEMORY_DEPTH(64), .ADDR_WIDTH(32), .BASE_ADDR(32'h10010000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic e, input logic [31:0] d);
    check_eq({tag, ".valid"}, {31'd0, bus.Read_Valid_o}, {31'd0, v});
    check_eq({tag, ".error"}, {31'd0, bus.Error_o}, {31'd0, e});
    check_eq({tag, ".data"}, bus.Read_Data_o, d);
  endtask

  task automatic xfer(input logic req, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd);
    bus.Req_i          = req;
    bus.Write_Enable_i = we;
    bus.Size_i         = sz;
    bus.Unsigned_i     = uns;
    bus.Address_i      = addr;
    bus.Write_Data_i   = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic st(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd);
    xfer(1'b1, 1'b1, sz, 1'b0, addr, wd);
  endtask

  task automatic ld(input logic [1:0] sz, input logic uns, input logic [31:0] addr);
    xfer(1'b1, 1'b0, sz, uns, addr, 32'h0);
  endtask

  task automatic idle();
    xfer(1'b0, 1'b0, SZW, 1'b0, B, 32'h0);
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    bus.Req_i = 1'b0; bus.Write_Enable_i = 1'b0; bus.Size_i = SZW;
    bus.Unsigned_i = 1'b0; bus.Address_i = B; bus.Write_Data_i = 32'h0;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 1'b0, 32'h0);
    reset = 1'b1;

    // word store/load round trip
    st(SZW, B, 32'h12345678);
    chk_out("st_w0", 1'b0, 1'b0, 32'h0);
    ld(SZW, 1'b0, B);
    chk_out("ld_w0", 1'b1, 1'b0, 32'h12345678);
    idle();
    chk_out("idle0", 1'b0, 1'b0, 32'h12345678);

    // byte store into a word of ones, signed/unsigned byte loads
    st(SZW, B + 32'h8, 32'hFFFFFFFF);
    st(SZB, B + 32'hA, 32'h00000080);
    ld(SZB, 1'b0, B + 32'hA);
    chk_out("ld_bs", 1'b1, 1'b0, 32'hFFFFFF80);
    ld(SZB, 1'b1, B + 32'hA);
    chk_out("ld_bu", 1'b1, 1'b0, 32'h00000080);
    ld(SZW, 1'b0, B + 32'h8);
    chk_out("ld_w8", 1'b1, 1'b0, 32'hFF80FFFF);

    // half store into upper lanes, lower lanes kept
    st(SZW, B + 32'h10, 32'h11223344);
    st(SZH, B + 32'h12, 32'h0000A0B1);
    ld(SZH, 1'b0, B + 32'h12);
    chk_out("ld_hs", 1'b1, 1'b0, 32'hFFFFA0B1);
    ld(SZH, 1'b1, B + 32'h12);
    chk_out("ld_hu", 1'b1, 1'b0, 32'h0000A0B1);
    ld(SZW, 1'b0, B + 32'h10);
    chk_out("ld_w10", 1'b1, 1'b0, 32'hA0B13344);

    // rejected accesses: one-cycle error, no valid, data and memory unchanged
    st(SZW, B + 32'h4, 32'h55667788);
    ld(SZW, 1'b0, B + 32'h4);
    chk_out("ld_w4", 1'b1, 1'b0, 32'h55667788);
    st(SZW, B + 32'h6, 32'hDEADBEEF);
    chk_out("err_st_mis", 1'b0, 1'b1, 32'h55667788);
    ld(SZH, 1'b0, B + 32'h1);
    chk_out("err_ld_h1", 1'b0, 1'b1, 32'h55667788);
    st(SZX, B, 32'h00000000);
    chk_out("err_sz11", 1'b0, 1'b1, 32'h55667788);
    ld(SZW, 1'b0, B + 32'h100);
    chk_out("err_hi", 1'b0, 1'b1, 32'h55667788);
    st(SZW, 32'h1000FFFC, 32'hDEADBEEF);
    chk_out("err_lo", 1'b0, 1'b1, 32'h55667788);
    idle();
    chk_out("err_clr", 1'b0, 1'b0, 32'h55667788);
    ld(SZW, 1'b0, B + 32'h4);
    chk_out("keep_w4", 1'b1, 1'b0, 32'h55667788);
    ld(SZW, 1'b0, B);
    chk_out("keep_w0", 1'b1, 1'b0, 32'h12345678);

    // last word in range is accessible
    st(SZW, B + 32'hFC, 32'hCAFEF00D);
    chk_out("st_top", 1'b0, 1'b0, 32'h12345678);
    ld(SZW, 1'b0, B + 32'hFC);
    chk_out("ld_top", 1'b1, 1'b0, 32'hCAFEF00D);

    // store immediately followed by load of the same word
    st(SZW, B + 32'hC, 32'h98761234);
    ld(SZW, 1'b0, B + 32'hC);
    chk_out("raw_c", 1'b1, 1'b0, 32'h98761234);

    // back-to-back loads give back-to-back pulses in order
    ld(SZW, 1'b0, B);
    chk_out("b2b_0", 1'b1, 1'b0, 32'h12345678);
    ld(SZW, 1'b0, B + 32'h4);
    chk_out("b2b_1", 1'b1, 1'b0, 32'h55667788);
    ld(SZW, 1'b0, B + 32'h8);
    chk_out("b2b_2", 1'b1, 1'b0, 32'hFF80FFFF);

    // reset drops an issued load and clears outputs immediately
    bus.Req_i = 1'b1; bus.Write_Enable_i = 1'b0; bus.Size_i = SZW;
    bus.Address_i = B + 32'hC;
    #2 reset = 1'b0;
    #1;
    chk_out("rst_async", 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    chk_out("rst_hold", 1'b0, 1'b0, 32'h0);
    bus.Req_i = 1'b0;
    reset = 1'b1;
    idle();
    chk_out("rst_idle", 1'b0, 1'b0, 32'h0);
    ld(SZW, 1'b0, B + 32'hC);
    chk_out("rst_keep", 1'b1, 1'b0, 32'h98761234);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
